trap_anim_scheduler: RTL and testbench
======================================

// Module: trap_anim_scheduler
// PURPOSE
//  Sequences the level's trap animations (pits, spikes) for the level state machine.
//  Arms N_TRAPS traps and fires each one when the player's x_pos passes its trigger column.
//  Steps each fired trap's animation frame on one shared frame tick. Exposes per-trap phase and frame to the renderer and collision logic.
//  Player death re-arms every trap.
// PARAMETERS
//  N_TRAPS     3                  number of trap channels
//  TICK_DIV    50000              clk cycles per animation frame tick
//  LAST_FRAME  6                  final frame index of the opening animation
//  FRAME_W     7                  frame number width
//  TRIG_X      {10'd480,10'd360,10'd200}  packed 10-bit trigger columns; trap i uses TRIG_X[10*i+:10]
//  HOLD_TICKS  8                  ticks held open before closing (TRAP_AUTOCLOSE_EN only)
// PORTS
//  clk           in   1                  system clock
//  reset         in   1                  asynchronous, active-high reset
//  x_pos         in   10                 player x position (pixels)
//  death         in   1                  player died; synchronous re-arm request
//  enable        in   1                  level running; 0 freezes triggering and frame stepping
//  trap_opening  out  N_TRAPS            trap i animating open (or closing)
//  trap_opened   out  N_TRAPS            trap i fully open: hazard live for collision
//  frame_num     out  N_TRAPS*FRAME_W    trap i frame at [FRAME_W*i+:FRAME_W]
//  any_animating out  1                  OR of trap_opening
// BEHAVIOUR
//  Interface: one clock (clk); reset is asynchronous and active-high.
//  Reset state: tick counter 0; every trap ARMED with frame 0; all outputs 0.
//  Tick divider: free-running 0..TICK_DIV-1 counter, advancing only while enable=1.
//   - tick = 1 for exactly one cycle when count==TICK_DIV-1 && enable.
//   - Reset clears the counter. Death does not.
//   - Accepted consequence: the first frame after a trigger lasts 1..TICK_DIV cycles.
//  Per-trap FSM, all transitions registered. Priority: death > enable=0 (hold) > normal.
//   ARMED:   if enable && x_pos > TRIG_X[i] -> OPENING, frame 0. The comparison is strict.
//   OPENING: on tick, frame+1. On the tick where frame+1==LAST_FRAME -> OPENED; frame stays LAST_FRAME.
//   OPENED:  terminal until death/reset; frame held at LAST_FRAME.
//  Output decode: trap_opening = (state==OPENING|CLOSING); trap_opened = (state==OPENED).
//   Both decode directly from state registers, with no extra latency.
//  Latency: trigger condition true at cycle n -> trap_opening=1 at n+1.
//   Full open takes LAST_FRAME ticks after that.
//  death=1 in any cycle: the next cycle every trap is ARMED with frame 0.
//   Death overrides a same-cycle trigger and a same-cycle tick.
//   Triggering resumes the cycle after death deasserts, if x_pos still exceeds TRIG_X.
//  Multiple traps may trigger and animate simultaneously; all step on the same tick.
//  Frame arithmetic is unsigned FRAME_W bits. LAST_FRAME < 2**FRAME_W is required, so the frame never wraps.
//  Reset asserted mid-animation: immediate return to the reset state.
// CONFIGURATION
//  TRAP_AUTOCLOSE_EN defined:
//   - OPENED counts HOLD_TICKS ticks, then -> CLOSING.
//   - CLOSING: frame-1 on each tick; on the tick where frame reaches 0 -> ARMED.
//   - Re-trigger is immediate if x_pos is still past TRIG_X, giving a cyclic trap.
//   - Adds a per-trap hold counter of width clog2(HOLD_TICKS+1).
//  Not defined: CLOSING state and hold counter are absent; OPENED is terminal; HOLD_TICKS is ignored.
// STRUCTURE
//  Shared package trap_pkg:
//   - state encoding localparams TRAP_ARMED=2'd0, TRAP_OPENING=2'd1, TRAP_OPENED=2'd2, TRAP_CLOSING=2'd3;
//   - default FRAME_W and LAST_FRAME constants, shared with the level state machine and renderer.
//  Sub-module trap_channel: one trap FSM plus frame (and hold) counter.
//   - Inputs: trigger, tick, death, enable.
//   - Instantiated N_TRAPS times by generate.
//  The top holds the tick divider, the x_pos comparators and output packing.
// TESTING (bench uses TICK_DIV=4, LAST_FRAME=6, TRIG_X={480,360,200})
//  1. Reset, x_pos=100, run 100 cycles -> all trap_opening/trap_opened 0, frame_num all 0.
//  2. x_pos steps 100->201 -> trap0 opening next cycle; frame0 counts 0..6 on 6 ticks; then trap_opened[0]=1 and frame0 holds at 6.
//  3. x_pos=200 exactly -> no trigger; x_pos=361 -> traps 0 and 1 both open, stepping on identical ticks.
//  4. death pulse at trap1 frame 3 -> next cycle all traps ARMED, frames 0; with x_pos=361 held, traps 0 and 1 re-trigger the cycle after death drops.
//  5. enable=0 mid-OPENING for 20 cycles -> frame and tick counter frozen; enable=1 resumes from the same frame.
//  6. TRAP_AUTOCLOSE_EN, HOLD_TICKS=2 -> OPENED for 2 ticks, then CLOSING with frame 6->0, then ARMED, then re-opens while x_pos>TRIG_X.

Source files
------------

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared trap state encoding and default animation constants
package trap_pkg;

  typedef logic [1:0] trap_state_t;

  localparam trap_state_t TRAP_ARMED   = 2'd0;
  localparam trap_state_t TRAP_OPENING = 2'd1;
  localparam trap_state_t TRAP_OPENED  = 2'd2;
  localparam trap_state_t TRAP_CLOSING = 2'd3;

  localparam int DEF_FRAME_W    = 7;
  localparam int DEF_LAST_FRAME = 6;

endpackage

// File: rtl/trap_channel.sv
// rtl/trap_channel.sv - one trap FSM with frame counter (hold counter when TRAP_AUTOCLOSE_EN)
module trap_channel
  import trap_pkg::*;
#(
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int LAST_FRAME = DEF_LAST_FRAME,
  parameter int HOLD_TICKS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic               tick,
  input  logic               death,
  input  logic               enable,
  output logic               opening,
  output logic               opened,
  output logic [FRAME_W-1:0] frame
);

  localparam logic [FRAME_W-1:0] LAST_F = FRAME_W'(LAST_FRAME);

  trap_state_t        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

`ifdef TRAP_AUTOCLOSE_EN
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_F = HOLD_W'(HOLD_TICKS);
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TRAP_ARMED;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end

  // death outranks the enable freeze, which outranks normal sequencing
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
`ifdef TRAP_AUTOCLOSE_EN
    hold_d  = hold_q;
`endif
    if (death) begin
      state_d = TRAP_ARMED;
      frame_d = '0;
`ifdef TRAP_AUTOCLOSE_EN
      hold_d  = '0;
`endif
    end else if (enable) begin
      case (state_q)
        TRAP_ARMED: begin
          if (trigger) begin
            state_d = TRAP_OPENING;
            frame_d = '0;
          end
        end
        TRAP_OPENING: begin
          if (tick) begin
            frame_d = frame_q + 1'b1;
            if (frame_q + 1'b1 == LAST_F) state_d = TRAP_OPENED;
          end
        end
`ifdef TRAP_AUTOCLOSE_EN
        TRAP_OPENED: begin
          if (tick) begin
            if (hold_q + 1'b1 == HOLD_F) begin
              state_d = TRAP_CLOSING;
              hold_d  = '0;
            end else begin
              hold_d  = hold_q + 1'b1;
            end
          end
        end
        TRAP_CLOSING: begin
          if (tick) begin
            frame_d = frame_q - 1'b1;
            if (frame_q == FRAME_W'(1)) state_d = TRAP_ARMED;
          end
        end
`else
        TRAP_OPENED: state_d = TRAP_OPENED;
        default:     state_d = TRAP_ARMED;
`endif
      endcase
    end
  end

  always_comb begin
    opening = (state_q == TRAP_OPENING) || (state_q == TRAP_CLOSING);
    opened  = (state_q == TRAP_OPENED);
    frame   = frame_q;
  end

endmodule

// File: rtl/trap_anim_scheduler.sv
// rtl/trap_anim_scheduler.sv - trap trigger/animation scheduler; optional TRAP_AUTOCLOSE_EN closes traps after a hold
module trap_anim_scheduler
  import trap_pkg::*;
#(
  parameter int                    N_TRAPS    = 3,
  parameter int                    TICK_DIV   = 50000,
  parameter int                    LAST_FRAME = DEF_LAST_FRAME,
  parameter int                    FRAME_W    = DEF_FRAME_W,
  parameter logic [10*N_TRAPS-1:0] TRIG_X     = {10'd480, 10'd360, 10'd200},
  parameter int                    HOLD_TICKS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 x_pos,
  input  logic                       death,
  input  logic                       enable,
  output logic [N_TRAPS-1:0]         trap_opening,
  output logic [N_TRAPS-1:0]         trap_opened,
  output logic [N_TRAPS*FRAME_W-1:0] frame_num,
  output logic                       any_animating
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic [N_TRAPS-1:0] trigger;

  assign tick = enable && (tick_cnt == CNT_MAX);

  // death deliberately leaves the divider running so frame pacing stays global
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       tick_cnt <= '0;
    else if (enable) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_TRAPS; i++) begin : g_trap
    assign trigger[i] = x_pos > TRIG_X[10*i +: 10];

    trap_channel #(
      .FRAME_W   (FRAME_W),
      .LAST_FRAME(LAST_FRAME),
      .HOLD_TICKS(HOLD_TICKS)
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .trigger(trigger[i]),
      .tick   (tick),
      .death  (death),
      .enable (enable),
      .opening(trap_opening[i]),
      .opened (trap_opened[i]),
      .frame  (frame_num[FRAME_W*i +: FRAME_W])
    );
  end

  assign any_animating = |trap_opening;

endmodule

// File: tb/tb_trap_anim_scheduler.sv
// tb/tb_trap_anim_scheduler.sv - self-checking bench for trap_anim_scheduler
module tb_trap_anim_scheduler;

  localparam int N  = 3;
  localparam int TD = 4;
  localparam int LF = 6;
  localparam int FW = 7;
  localparam int HT = 2;
  localparam logic [10*N-1:0] TX = {10'd480, 10'd360, 10'd200};

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [9:0]     x_pos = 10'd100;
  logic           death = 1'b0;
  logic           enable = 1'b1;
  logic [N-1:0]   trap_opening;
  logic [N-1:0]   trap_opened;
  logic [N*FW-1:0] frame_num;
  logic           any_animating;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trap_anim_scheduler #(
    .N_TRAPS   (N),
    .TICK_DIV  (TD),
    .LAST_FRAME(LF),
    .FRAME_W   (FW),
    .TRIG_X    (TX),
    .HOLD_TICKS(HT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .x_pos        (x_pos),
    .death        (death),
    .enable       (enable),
    .trap_opening (trap_opening),
    .trap_opened  (trap_opened),
    .frame_num    (frame_num),
    .any_animating(any_animating)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a trap is either idle or counts ticks since it fired; phase and frame follow from that count.
  int m_cnt;
  bit m_act[N];
  int m_ticks[N];
  int trig[N];

  initial begin
    for (int i = 0; i < N; i++) trig[i] = int'(TX[10*i +: 10]);
  end

  initial begin
    logic [N-1:0]    e_op, e_od;
    logic [N*FW-1:0] e_fr;
    bit tk;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin m_act[i] = 0; m_ticks[i] = 0; end
      end else begin
        tk = enable && (m_cnt == TD - 1);
        if (enable) m_cnt = tk ? 0 : m_cnt + 1;
        for (int i = 0; i < N; i++) begin
          if (death) begin
            m_act[i] = 0; m_ticks[i] = 0;
          end else if (enable) begin
            if (!m_act[i]) begin
              if (int'(x_pos) > trig[i]) begin m_act[i] = 1; m_ticks[i] = 0; end
            end else if (tk) begin
`ifdef TRAP_AUTOCLOSE_EN
              m_ticks[i]++;
              if (m_ticks[i] == 2*LF + HT) begin m_act[i] = 0; m_ticks[i] = 0; end
`else
              if (m_ticks[i] < LF) m_ticks[i]++;
`endif
            end
          end
        end
      end
      #1;
      e_op = '0; e_od = '0; e_fr = '0;
      for (int i = 0; i < N; i++) begin
        if (m_act[i]) begin
          if (m_ticks[i] < LF) begin
            e_op[i] = 1'b1; e_fr[FW*i +: FW] = FW'(m_ticks[i]);
`ifdef TRAP_AUTOCLOSE_EN
          end else if (m_ticks[i] < LF + HT) begin
            e_od[i] = 1'b1; e_fr[FW*i +: FW] = FW'(LF);
          end else begin
            e_op[i] = 1'b1; e_fr[FW*i +: FW] = FW'(2*LF + HT - m_ticks[i]);
`else
          end else begin
            e_od[i] = 1'b1; e_fr[FW*i +: FW] = FW'(LF);
`endif
          end
        end
      end
      chk("model_opening", 32'(trap_opening), 32'(e_op));
      chk("model_opened", 32'(trap_opened), 32'(e_od));
      chk("model_frame", 32'(frame_num), 32'(e_fr));
      chk("model_any", 32'(any_animating), 32'(|e_op));
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle below every trigger column
    repeat (100) @(negedge clk);
    chk("t1_opening", 32'(trap_opening), 0);
    chk("t1_opened", 32'(trap_opened), 0);
    chk("t1_frames", 32'(frame_num), 0);

    // 2: trap0 fires and opens fully
    x_pos = 10'd201;
    @(negedge clk);
    chk("t2_open_next", 32'(trap_opening), 32'b001);
    chk("t2_frame0_start", 32'(frame_num[FW-1:0]), 0);
    k = 0;
    while (!trap_opened[0] && k < 60) begin @(negedge clk); k++; end
    chk("t2_opened", 32'(trap_opened), 32'b001);
    chk("t2_frame0_last", 32'(frame_num[FW-1:0]), 6);
`ifndef TRAP_AUTOCLOSE_EN
    repeat (20) @(negedge clk);
    chk("t2_frame0_hold", 32'(frame_num[FW-1:0]), 6);
`endif

    // 3: exact column does not trigger; 361 fires traps 0 and 1 together
    x_pos = 10'd200;
    death = 1'b1;
    @(negedge clk);
    death = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_strict_opening", 32'(trap_opening), 0);
    chk("t3_strict_frames", 32'(frame_num), 0);
    x_pos = 10'd361;
    @(negedge clk);
    chk("t3_two_open", 32'(trap_opening), 32'b011);

    // 4: death at trap1 frame 3 re-arms everything, then re-trigger
    k = 0;
    while (frame_num[FW +: FW] != 3 && k < 60) begin @(negedge clk); k++; end
    chk("t4_wait_frame3", 32'(frame_num[FW +: FW]), 3);
    death = 1'b1;
    @(negedge clk);
    chk("t4_death_opening", 32'(trap_opening), 0);
    chk("t4_death_opened", 32'(trap_opened), 0);
    chk("t4_death_frames", 32'(frame_num), 0);
    death = 1'b0;
    @(negedge clk);
    chk("t4_retrigger", 32'(trap_opening), 32'b011);

    // 5: enable low freezes animation mid-open
    k = 0;
    while (frame_num[FW-1:0] != 2 && k < 60) begin @(negedge clk); k++; end
    chk("t5_wait_frame2", 32'(frame_num[FW-1:0]), 2);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_frozen_frame", 32'(frame_num[FW-1:0]), 2);
    chk("t5_frozen_opening", 32'(trap_opening), 32'b011);
    enable = 1'b1;
    k = 0;
    while (!trap_opened[0] && k < 60) begin @(negedge clk); k++; end
    chk("t5_resume_opened", 32'(trap_opened), 32'b011);
    chk("t5_resume_frame", 32'(frame_num[FW-1:0]), 6);

`ifdef TRAP_AUTOCLOSE_EN
    // 6: hold, close back to frame 0, re-arm and immediately re-open
    k = 0;
    while (!trap_opening[0] && k < 60) begin @(negedge clk); k++; end
    chk("t6_closing", 32'(trap_opening[0]), 1);
    chk("t6_closing_frame", 32'(frame_num[FW-1:0]), 6);
    k = 0;
    while ((trap_opening[0] || trap_opened[0]) && k < 60) begin @(negedge clk); k++; end
    chk("t6_armed", 32'({trap_opening[0], trap_opened[0]}), 0);
    chk("t6_armed_frame", 32'(frame_num[FW-1:0]), 0);
    @(negedge clk);
    chk("t6_reopen", 32'(trap_opening[0]), 1);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
